// File: rtl/bus_datapath.sv
// Single-bus 32-bit CPU datapath: GPRs, PC, IR, HI, LO, Y, Z, MAR, MDR and ALU
// share one bus; the control-step sequencer picks one source and any loads per cycle.
module bus_datapath (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
   input  logic        R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
   input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
   input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
   input  logic        HIin,
   input  logic        LOin,
   input  logic        PCin,
   input  logic        IRin,
   input  logic        Yin,
   input  logic        Zin,
   input  logic        MDRin,
   input  logic        MARin,
   input  logic        HIout,
   input  logic        LOout,
   input  logic        PCout,
   input  logic        MDRout,
   input  logic        ZLowout,
   input  logic        ZHighout,
   input  logic        InPortout,
   input  logic        Cout,
   input  logic        MDRread,
   input  logic        IncPC,
   input  logic [3:0]  ALUselect,
   input  logic [31:0] MDatain,
   output logic [31:0] R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,
   output logic [31:0] R8,  R9,  R10, R11, R12, R13, R14, R15,
   output logic [63:0] ZReg,
   output logic [31:0] BusMuxOut,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] IR
);

   logic [15:0] gpr_in;
   logic [15:0] gpr_out;
   logic [31:0] gpr [16];
   logic [31:0] pc;
   logic [31:0] y;
   logic [31:0] mar;
   logic [31:0] mdr;
   logic [63:0] alu_result;
   logic [63:0] product;
   logic [63:0] rot_left;
   logic [63:0] rot_right;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic [4:0]  shamt;
   logic        unused_mar;

   assign gpr_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
   assign gpr_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

   assign R0  = gpr[0];
   assign R1  = gpr[1];
   assign R2  = gpr[2];
   assign R3  = gpr[3];
   assign R4  = gpr[4];
   assign R5  = gpr[5];
   assign R6  = gpr[6];
   assign R7  = gpr[7];
   assign R8  = gpr[8];
   assign R9  = gpr[9];
   assign R10 = gpr[10];
   assign R11 = gpr[11];
   assign R12 = gpr[12];
   assign R13 = gpr[13];
   assign R14 = gpr[14];
   assign R15 = gpr[15];

   // MAR feeds the memory address path, which is not part of this block yet
   assign unused_mar = ^mar;

   // Descending loop so the lowest-numbered GPR wins when several drive at once
   always_comb begin
      BusMuxOut = 32'h0;
      if (|gpr_out) begin
         for (int i = 15; i >= 0; i--) begin
            if (gpr_out[i]) BusMuxOut = gpr[i];
         end
      end
      else if (HIout)     BusMuxOut = HI;
      else if (LOout)     BusMuxOut = LO;
      else if (ZHighout)  BusMuxOut = ZReg[63:32];
      else if (ZLowout)   BusMuxOut = ZReg[31:0];
      else if (PCout)     BusMuxOut = pc;
      else if (MDRout)    BusMuxOut = mdr;
      else if (InPortout) BusMuxOut = 32'h0;
      else if (Cout)      BusMuxOut = {{13{IR[18]}}, IR[18:0]};
   end

   assign shamt     = BusMuxOut[4:0];
   assign product   = {{32{y[31]}}, y} * {{32{BusMuxOut[31]}}, BusMuxOut};
   assign quotient  = $signed(y) / $signed(BusMuxOut);
   assign remainder = $signed(y) % $signed(BusMuxOut);
   assign rot_left  = {y, y} << shamt;
   assign rot_right = {y, y} >> shamt;

   always_comb begin
      alu_result = 64'h0;
      if (IncPC) begin
         alu_result = {32'h0, BusMuxOut + 32'd1};
      end
      else begin
         case (ALUselect)
            4'b0000: alu_result = {32'h0, BusMuxOut};
            4'b0001: alu_result = {32'h0, y + BusMuxOut};
            4'b0010: alu_result = {32'h0, y - BusMuxOut};
            4'b0011: alu_result = product;
            4'b0101: alu_result = (BusMuxOut == 32'h0) ? {y, 32'hFFFF_FFFF}
                                                       : {remainder, quotient};
            4'b0110: alu_result = {32'h0, y & BusMuxOut};
            4'b0111: alu_result = {32'h0, y | BusMuxOut};
            4'b1000: alu_result = {32'h0, 32'h0 - BusMuxOut};
            4'b1010: alu_result = {32'h0, ~BusMuxOut};
            4'b1100: alu_result = {32'h0, y << shamt};
            4'b1101: alu_result = {32'h0, y >> shamt};
            4'b1110: alu_result = {32'h0, rot_left[63:32]};
            4'b1111: alu_result = {32'h0, rot_right[31:0]};
            default: alu_result = 64'h0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int i = 0; i < 16; i++) gpr[i] <= 32'h0;
         pc   <= 32'h0;
         IR   <= 32'h0;
         HI   <= 32'h0;
         LO   <= 32'h0;
         y    <= 32'h0;
         ZReg <= 64'h0;
         mar  <= 32'h0;
         mdr  <= 32'h0;
      end
      else begin
         for (int i = 0; i < 16; i++) begin
            if (gpr_in[i]) gpr[i] <= BusMuxOut;
         end
         if (PCin)  pc   <= BusMuxOut;
         if (IRin)  IR   <= BusMuxOut;
         if (HIin)  HI   <= BusMuxOut;
         if (LOin)  LO   <= BusMuxOut;
         if (Yin)   y    <= BusMuxOut;
         if (Zin)   ZReg <= alu_result;
         if (MARin) mar  <= BusMuxOut;
         if (MDRin) mdr  <= MDRread ? MDatain : BusMuxOut;
      end
   end

endmodule

// File: tb/tb_bus_datapath.sv
// Directed bench for bus_datapath: ALU vector table driven through the bus
// sequence, plus fetch, bus priority, constant, simultaneous-load and reset sequences.
module tb_bus_datapath;

   logic        clk;
   logic        clr_n;
   logic [15:0] r_in_v;
   logic [15:0] r_out_v;
   logic        hi_in, lo_in, pc_in, ir_in, y_in, z_in, mdr_in, mar_in;
   logic        hi_out, lo_out, pc_out, mdr_out, zlow_out, zhigh_out, inport_out, c_out;
   logic        mdr_read, inc_pc;
   logic [3:0]  alu_sel;
   logic [31:0] mdata_in;
   logic [31:0] r_q [16];
   logic [63:0] z_reg;
   logic [31:0] bus_val, hi_q, lo_q, ir_q;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       name;
      logic [3:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_lo;
      logic [31:0] exp_hi;
   } vec_t;

   vec_t vecs[$];

   bus_datapath dut (
      .clk(clk), .clr_n(clr_n),
      .R0in(r_in_v[0]),   .R1in(r_in_v[1]),   .R2in(r_in_v[2]),   .R3in(r_in_v[3]),
      .R4in(r_in_v[4]),   .R5in(r_in_v[5]),   .R6in(r_in_v[6]),   .R7in(r_in_v[7]),
      .R8in(r_in_v[8]),   .R9in(r_in_v[9]),   .R10in(r_in_v[10]), .R11in(r_in_v[11]),
      .R12in(r_in_v[12]), .R13in(r_in_v[13]), .R14in(r_in_v[14]), .R15in(r_in_v[15]),
      .R0out(r_out_v[0]),   .R1out(r_out_v[1]),   .R2out(r_out_v[2]),   .R3out(r_out_v[3]),
      .R4out(r_out_v[4]),   .R5out(r_out_v[5]),   .R6out(r_out_v[6]),   .R7out(r_out_v[7]),
      .R8out(r_out_v[8]),   .R9out(r_out_v[9]),   .R10out(r_out_v[10]), .R11out(r_out_v[11]),
      .R12out(r_out_v[12]), .R13out(r_out_v[13]), .R14out(r_out_v[14]), .R15out(r_out_v[15]),
      .HIin(hi_in), .LOin(lo_in), .PCin(pc_in), .IRin(ir_in), .Yin(y_in), .Zin(z_in),
      .MDRin(mdr_in), .MARin(mar_in),
      .HIout(hi_out), .LOout(lo_out), .PCout(pc_out), .MDRout(mdr_out),
      .ZLowout(zlow_out), .ZHighout(zhigh_out), .InPortout(inport_out), .Cout(c_out),
      .MDRread(mdr_read), .IncPC(inc_pc), .ALUselect(alu_sel), .MDatain(mdata_in),
      .R0(r_q[0]),   .R1(r_q[1]),   .R2(r_q[2]),   .R3(r_q[3]),
      .R4(r_q[4]),   .R5(r_q[5]),   .R6(r_q[6]),   .R7(r_q[7]),
      .R8(r_q[8]),   .R9(r_q[9]),   .R10(r_q[10]), .R11(r_q[11]),
      .R12(r_q[12]), .R13(r_q[13]), .R14(r_q[14]), .R15(r_q[15]),
      .ZReg(z_reg), .BusMuxOut(bus_val), .HI(hi_q), .LO(lo_q), .IR(ir_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clearControls;
      r_in_v = '0;  r_out_v = '0;
      hi_in = 0; lo_in = 0; pc_in = 0; ir_in = 0; y_in = 0; z_in = 0; mdr_in = 0; mar_in = 0;
      hi_out = 0; lo_out = 0; pc_out = 0; mdr_out = 0; zlow_out = 0; zhigh_out = 0;
      inport_out = 0; c_out = 0; mdr_read = 0; inc_pc = 0; alu_sel = 4'h0; mdata_in = 32'h0;
   endtask

   // One control step: the controls set beforehand are latched, then cleared
   task automatic applyStimulus;
      @(posedge clk);
      #1;
      clearControls();
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic loadGpr(input int idx, input logic [31:0] value);
      mdr_read = 1; mdr_in = 1; mdata_in = value;
      applyStimulus();
      mdr_out = 1; r_in_v[idx] = 1;
      applyStimulus();
   endtask

   task automatic runAluVector(input vec_t v);
      loadGpr(2, v.a);
      loadGpr(4, v.b);
      r_out_v[2] = 1; y_in = 1;
      applyStimulus();
      r_out_v[4] = 1; alu_sel = v.sel; z_in = 1;
      applyStimulus();
      checkOutput({v.name, "_Z"}, z_reg, {v.exp_hi, v.exp_lo});
      zlow_out = 1; r_in_v[5] = 1; lo_in = 1;
      applyStimulus();
      zhigh_out = 1; hi_in = 1;
      applyStimulus();
      checkOutput({v.name, "_R5"}, {32'h0, r_q[5]}, {32'h0, v.exp_lo});
      checkOutput({v.name, "_LO"}, {32'h0, lo_q}, {32'h0, v.exp_lo});
      checkOutput({v.name, "_HI"}, {32'h0, hi_q}, {32'h0, v.exp_hi});
   endtask

   initial begin
      clearControls();
      clr_n = 1'b0;

      vecs.push_back('{"add",     4'b0001, 32'h22,       32'h24, 32'h46,       32'h0});
      vecs.push_back('{"and",     4'b0110, 32'h22,       32'h24, 32'h20,       32'h0});
      vecs.push_back('{"or",      4'b0111, 32'h22,       32'h24, 32'h26,       32'h0});
      vecs.push_back('{"sub",     4'b0010, 32'h22,       32'h24, 32'hFFFFFFFE, 32'h0});
      vecs.push_back('{"mul",     4'b0011, 32'h22,       32'h24, 32'h4C8,      32'h0});
      vecs.push_back('{"mul_neg", 4'b0011, 32'hFFFFFFFE, 32'h3,  32'hFFFFFFFA, 32'hFFFFFFFF});
      vecs.push_back('{"div",     4'b0101, 32'h22,       32'h3,  32'hB,        32'h1});
      vecs.push_back('{"div_neg", 4'b0101, 32'hFFFFFFF9, 32'h2,  32'hFFFFFFFD, 32'hFFFFFFFF});
      vecs.push_back('{"div_zero",4'b0101, 32'h7,        32'h0,  32'hFFFFFFFF, 32'h7});
      vecs.push_back('{"shl",     4'b1100, 32'h22,       32'h3,  32'h110,      32'h0});
      vecs.push_back('{"shr",     4'b1101, 32'h22,       32'h3,  32'h4,        32'h0});
      vecs.push_back('{"ror",     4'b1111, 32'h80000022, 32'h3,  32'h50000004, 32'h0});
      vecs.push_back('{"rol",     4'b1110, 32'h80000022, 32'h3,  32'h00000114, 32'h0});
      vecs.push_back('{"not",     4'b1010, 32'h22,       32'h24, 32'hFFFFFFDB, 32'h0});
      vecs.push_back('{"neg",     4'b1000, 32'h22,       32'h24, 32'hFFFFFFDC, 32'h0});
      vecs.push_back('{"pass",    4'b0000, 32'h22,       32'h24, 32'h24,       32'h0});
      vecs.push_back('{"add_wrap",4'b0001, 32'hFFFFFFFF, 32'h2,  32'h1,        32'h0});
      vecs.push_back('{"shl_by32",4'b1100, 32'h22,       32'h20, 32'h22,       32'h0});
      vecs.push_back('{"ror_by0", 4'b1111, 32'h80000022, 32'h0,  32'h80000022, 32'h0});
      vecs.push_back('{"rol_by0", 4'b1110, 32'h80000022, 32'h0,  32'h80000022, 32'h0});
      vecs.push_back('{"op_0100", 4'b0100, 32'h22,       32'h24, 32'h0,        32'h0});
      vecs.push_back('{"op_1001", 4'b1001, 32'h22,       32'h24, 32'h0,        32'h0});
      vecs.push_back('{"op_1011", 4'b1011, 32'h22,       32'h24, 32'h0,        32'h0});

      #12;
      checkOutput("reset_Z",   z_reg, 64'h0);
      checkOutput("reset_bus", {32'h0, bus_val}, 64'h0);
      checkOutput("reset_IR",  {32'h0, ir_q}, 64'h0);
      checkOutput("reset_R0",  {32'h0, r_q[0]}, 64'h0);
      checkOutput("reset_R15", {32'h0, r_q[15]}, 64'h0);
      clr_n = 1'b1;
      @(posedge clk);
      #1;

      // Instruction fetch with PC starting at 0
      pc_out = 1; mar_in = 1; inc_pc = 1; z_in = 1;
      applyStimulus();
      checkOutput("fetch_Z", z_reg, 64'h1);
      zlow_out = 1; pc_in = 1;
      applyStimulus();
      mdr_read = 1; mdr_in = 1; mdata_in = 32'h89200000;
      applyStimulus();
      mdr_out = 1; ir_in = 1;
      applyStimulus();
      checkOutput("fetch_IR", {32'h0, ir_q}, {32'h0, 32'h89200000});
      pc_out = 1;
      #1;
      checkOutput("fetch_PC", {32'h0, bus_val}, 64'h1);
      clearControls();

      foreach (vecs[i]) runAluVector(vecs[i]);

      // Bus priority, idle bus, in-port and sign-extended constant
      loadGpr(0, 32'hA0A0A0A0);
      hi_in = 1; mdr_read = 0; mdr_out = 1;
      applyStimulus();
      r_out_v[0] = 1; hi_out = 1;
      #1;
      checkOutput("prio_R0_over_HI", {32'h0, bus_val}, {32'h0, 32'hA0A0A0A0});
      clearControls();
      r_out_v[7] = 1; r_out_v[3] = 1;
      #1;
      checkOutput("prio_R3_over_R7", {32'h0, bus_val}, {32'h0, r_q[3]});
      clearControls();
      #1;
      checkOutput("bus_idle", {32'h0, bus_val}, 64'h0);
      inport_out = 1;
      #1;
      checkOutput("bus_inport", {32'h0, bus_val}, 64'h0);
      clearControls();
      mdr_read = 1; mdr_in = 1; mdata_in = 32'h00040005;
      applyStimulus();
      mdr_out = 1; ir_in = 1;
      applyStimulus();
      c_out = 1;
      #1;
      checkOutput("cout_sext", {32'h0, bus_val}, {32'h0, 32'hFFFC0005});
      clearControls();

      // Simultaneous loads and read-modify-write of Z in one cycle
      loadGpr(6, 32'h12345678);
      r_out_v[6] = 1; r_in_v[8] = 1; r_in_v[9] = 1;
      applyStimulus();
      checkOutput("multi_load_R8", {32'h0, r_q[8]}, {32'h0, 32'h12345678});
      checkOutput("multi_load_R9", {32'h0, r_q[9]}, {32'h0, 32'h12345678});
      r_out_v[6] = 1; inc_pc = 1; z_in = 1;
      applyStimulus();
      zlow_out = 1; inc_pc = 1; z_in = 1;
      applyStimulus();
      checkOutput("z_self_inc", z_reg, {32'h0, 32'h1234567A});

      // Asynchronous clear between edges, then loads resume
      loadGpr(3, 32'hDEADBEEF);
      #2;
      clr_n = 1'b0;
      #1;
      checkOutput("async_clr_R3",  {32'h0, r_q[3]}, 64'h0);
      checkOutput("async_clr_R6",  {32'h0, r_q[6]}, 64'h0);
      checkOutput("async_clr_Z",   z_reg, 64'h0);
      checkOutput("async_clr_IR",  {32'h0, ir_q}, 64'h0);
      checkOutput("async_clr_HI",  {32'h0, hi_q}, 64'h0);
      checkOutput("async_clr_LO",  {32'h0, lo_q}, 64'h0);
      #1;
      clr_n = 1'b1;
      @(posedge clk);
      #1;
      loadGpr(3, 32'h00C0FFEE);
      checkOutput("post_clr_R3", {32'h0, r_q[3]}, {32'h0, 32'h00C0FFEE});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
